eth_tx_frame_arb: RTL
=====================

Name: eth_tx_frame_arb

Overview:
- Frame-atomic, round-robin arbiter that shares the MAC direct-access TX data path between two frame sources, e.g. a DMA engine and a soft packet generator.
- It sits in the clk_app_i domain, between the requesters and the MAC tx_valid/tx_data/tx_start/tx_end/tx_bytesel/tx_ready interface.
- It routes each per-frame TX status word back to the requester that sent that frame.

Parameters:
- STAT_DEPTH, 4: number of frames that may be outstanding (sent, status not yet returned). Must be a power of two, 2..16.
- PTR_W, 2: log2(STAT_DEPTH).

Ports:
- clk_app_i  in  1  application clock
- rst_clk_app_n  in  1  asynchronous active-low reset
- arb_en_i  in  1  1 = new grants allowed; a frame already in progress always completes
- rq0_valid_i / rq1_valid_i  in  1  requester beat valid
- rq0_data_i / rq1_data_i  in  32  beat data
- rq0_start_i / rq1_start_i  in  1  first beat of a frame
- rq0_end_i / rq1_end_i  in  1  last beat of a frame
- rq0_bytesel_i / rq1_bytesel_i  in  2  valid bytes on the last beat, passed through unchanged
- rq0_ready_o / rq1_ready_o  out  1  beat accepted
- rq0_status_o / rq1_status_o  out  8  TX status of a returned frame
- rq0_status_valid_o / rq1_status_valid_o  out  1  one-cycle status strobe
- tx_valid_o  out  1  to MAC
- tx_data_o  out  32  to MAC
- tx_start_o  out  1  to MAC
- tx_end_o  out  1  to MAC
- tx_bytesel_o  out  2  to MAC
- tx_ready_i  in  1  from MAC
- tx_status_i  in  8  from MAC
- tx_status_valid_i  in  1  from MAC, one pulse per frame, in frame order
- owner_o  out  1  current or last granted requester
- busy_o  out  1  state == XFER
- drop_cnt_o  out  8  saturating count of beats discarded outside a frame
- orphan_o  out  1  one-cycle pulse: status arrived with no outstanding frame

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; last-grant pointer = 1, so requester 0 wins first.
  - owner FIFO empty; drop_cnt_o = 0.
- State machine: IDLE <-> XFER.
- IDLE:
  - A requester is eligible when valid & start.
  - A grant is made when arb_en_i = 1, at least one requester is eligible, and the owner FIFO is not full.
  - Round-robin choice: the requester other than the last-granted one wins a tie.
  - The grant is registered: the cycle after the decision, state = XFER and owner_o = the winner.
  - In IDLE, tx_valid_o = 0 and both rqN_ready_o = 0, except for the drop case below.
- Drop rule (IDLE only):
  - A requester presenting valid with start = 0 gets rqN_ready_o = 1 for that cycle and the beat is discarded.
  - drop_cnt_o increments, saturating at 255. If both requesters drop in the same cycle, the increment is 1.
- XFER:
  - tx_* outputs are a combinational mux of the owner's inputs.
  - Owner's ready = tx_ready_i; the non-owner's ready = 0.
  - A beat transfers on tx_valid_o & tx_ready_i.
  - A transferred beat with tx_end_o = 1 returns the state to IDLE next cycle and sets the last-grant pointer to the owner.
  - Start on a non-first beat is passed through unchanged; the arbiter does not check it.
  - A start&end beat is a single-beat frame: IDLE -> XFER -> IDLE.
  - Minimum gap: one IDLE cycle between frames.
- Owner FIFO:
  - Push the owner id on a transferred beat with tx_start_o = 1.
  - Pop on tx_status_valid_i: the popped id selects which rqN_status_valid_o pulses, in the same cycle (combinational), with rqN_status_o = tx_status_i. The other requester's status output holds 0.
  - Simultaneous push and pop are both performed; the occupancy count is unchanged.
  - Pop when empty: no strobe, orphan_o pulses, FIFO stays empty.
  - Full: no new grant until a pop. A frame already in XFER is unaffected, because its push happened at its start.
- arb_en_i:
  - Deassertion mid-frame has no effect on the frame in progress.
  - Status routing continues regardless of arb_en_i.
- Asynchronous reset mid-frame: the state machine, FIFO, counter and pointer clear immediately. The MAC sees tx_valid_o drop without an end beat; aborting that frame is the MAC's responsibility.

Test Plan:
1. Single frame: rq0 sends 3 beats (start on D0=0x11111111, end on D2 with bytesel=2'b10), tx_ready_i=1 → grant in 1 cycle; tx_data_o = D0,D1,D2 on consecutive cycles; then IDLE. tx_status_i=0x5A strobe → rq0_status_valid_o=1 with 0x5A; rq1 sees nothing.
2. Contention: both requesters continuously eligible with 2-beat frames → grant order rq0, rq1, rq0, rq1; owner_o alternates; rq1_ready_o is never 1 while rq0 owns the path.
3. Backpressure: tx_ready_i toggles 1,0,0,1 mid-frame → tx outputs hold during stall; the owner's ready mirrors tx_ready_i; no beat is lost or duplicated.
4. FIFO full (STAT_DEPTH=4): 4 frames sent, no status returned → a 5th eligible request is not granted (busy_o=0). One status pulse → grant the following cycle. Statuses 0x01..0x04 route to the owners in send order.
5. Errors:
   - rq1 asserts valid without start in IDLE for 3 cycles → rq1_ready_o=1 each cycle; drop_cnt_o=3.
   - tx_status_valid_i with the FIFO empty → orphan_o pulses once; no requester strobe.
6. Control and reset: arb_en_i=0 during a frame → the frame completes; no new grant until arb_en_i=1. Reset asserted mid-frame → all outputs 0 immediately; the first grant after release goes to rq0.

Source files
------------

// File: rtl/eth_tx_frame_arb_if.sv
// Handshake bundle between two frame requesters, the arbiter and the MAC
// direct-access TX port. The arbiter takes the slave view; the requesters
// and the MAC together form the master view.
interface eth_tx_frame_arb_if;
  logic        rq0_valid;
  logic [31:0] rq0_data;
  logic        rq0_start;
  logic        rq0_end;
  logic [1:0]  rq0_bytesel;
  logic        rq0_ready;
  logic [7:0]  rq0_status;
  logic        rq0_status_valid;

  logic        rq1_valid;
  logic [31:0] rq1_data;
  logic        rq1_start;
  logic        rq1_end;
  logic [1:0]  rq1_bytesel;
  logic        rq1_ready;
  logic [7:0]  rq1_status;
  logic        rq1_status_valid;

  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_start;
  logic        tx_end;
  logic [1:0]  tx_bytesel;
  logic        tx_ready;
  logic [7:0]  tx_status;
  logic        tx_status_valid;

  modport slave (
    input  rq0_valid, rq0_data, rq0_start, rq0_end, rq0_bytesel,
    input  rq1_valid, rq1_data, rq1_start, rq1_end, rq1_bytesel,
    input  tx_ready, tx_status, tx_status_valid,
    output rq0_ready, rq0_status, rq0_status_valid,
    output rq1_ready, rq1_status, rq1_status_valid,
    output tx_valid, tx_data, tx_start, tx_end, tx_bytesel
  );

  modport master (
    output rq0_valid, rq0_data, rq0_start, rq0_end, rq0_bytesel,
    output rq1_valid, rq1_data, rq1_start, rq1_end, rq1_bytesel,
    output tx_ready, tx_status, tx_status_valid,
    input  rq0_ready, rq0_status, rq0_status_valid,
    input  rq1_ready, rq1_status, rq1_status_valid,
    input  tx_valid, tx_data, tx_start, tx_end, tx_bytesel
  );
endinterface

// File: rtl/eth_tx_frame_arb.sv
// Frame-atomic round-robin arbiter for the MAC TX data path. Two requesters
// compete for whole frames; a small owner FIFO remembers who sent each
// outstanding frame so the per-frame TX status returns to the right source.
module eth_tx_frame_arb #(
  parameter int STAT_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic              clk_app_i,
  input  logic              rst_clk_app_n,
  input  logic              arb_en_i,
  eth_tx_frame_arb_if.slave bus,
  output logic              owner_o,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o,
  output logic              orphan_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic [7:0]       drop_cnt_q;
  logic             fifo_mem [STAT_DEPTH];

  logic elig0, elig1, win;
  logic drop_any, beat;
  logic fifo_full, fifo_empty;
  logic push, pop, pop_id;

  assign elig0      = bus.rq0_valid & bus.rq0_start;
  assign elig1      = bus.rq1_valid & bus.rq1_start;
  assign fifo_full  = (cnt_q == (PTR_W+1)'(STAT_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = bus.tx_status_valid & ~fifo_empty;
  assign pop_id     = fifo_mem[rd_ptr_q];
  // A start beat on a full FIFO only slips through if a slot frees this cycle.
  assign push       = beat & bus.tx_start & (~fifo_full | pop);

  // Arbitration, drop handling and the owner-driven TX mux.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    win            = 1'b0;
    drop_any       = 1'b0;
    beat           = 1'b0;
    bus.rq0_ready  = 1'b0;
    bus.rq1_ready  = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = '0;
    bus.tx_start   = 1'b0;
    bus.tx_end     = 1'b0;
    bus.tx_bytesel = '0;
    case (state_q)
      IDLE: begin
        // Beats arriving outside a frame are swallowed so a stray source
        // cannot stall; both dropping together still counts once.
        bus.rq0_ready = bus.rq0_valid & ~bus.rq0_start;
        bus.rq1_ready = bus.rq1_valid & ~bus.rq1_start;
        drop_any      = bus.rq0_ready | bus.rq1_ready;
        if (arb_en_i && (elig0 || elig1) && (!fifo_full || pop)) begin
          win     = (elig0 && elig1) ? ~last_q : elig1;
          state_d = XFER;
          owner_d = win;
        end
      end
      XFER: begin
        if (owner_q) begin
          bus.tx_valid   = bus.rq1_valid;
          bus.tx_data    = bus.rq1_data;
          bus.tx_start   = bus.rq1_start;
          bus.tx_end     = bus.rq1_end;
          bus.tx_bytesel = bus.rq1_bytesel;
          bus.rq1_ready  = bus.tx_ready;
        end else begin
          bus.tx_valid   = bus.rq0_valid;
          bus.tx_data    = bus.rq0_data;
          bus.tx_start   = bus.rq0_start;
          bus.tx_end     = bus.rq0_end;
          bus.tx_bytesel = bus.rq0_bytesel;
          bus.rq0_ready  = bus.tx_ready;
        end
        beat = bus.tx_valid & bus.tx_ready;
        if (beat && bus.tx_end) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, grant pointer, FIFO pointers/occupancy, drop counter.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop_any && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Owner ids of outstanding frames; validity is tracked by the pointers.
  always_ff @(posedge clk_app_i) begin
    if (push) fifo_mem[wr_ptr_q] <= owner_q;
  end

  assign bus.rq0_status_valid = pop & ~pop_id;
  assign bus.rq1_status_valid = pop & pop_id;
  assign bus.rq0_status       = (pop & ~pop_id) ? bus.tx_status : 8'h00;
  assign bus.rq1_status       = (pop & pop_id)  ? bus.tx_status : 8'h00;

  assign owner_o    = owner_q;
  assign busy_o     = (state_q == XFER);
  assign drop_cnt_o = drop_cnt_q;
  assign orphan_o   = bus.tx_status_valid & fifo_empty;

endmodule
